// File: rtl/cmd_sched.sv
// SD host command scheduler: arbitrates one software command slot against
// auto CMD12 requests, issues the winner to the command path and tracks completion.
module cmd_sched #(
    parameter int unsigned RspTimeout = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sd_clk_en_p_i,
    input  logic        sw_cmd_valid_i,
    input  logic [5:0]  sw_cmd_index_i,
    input  logic [31:0] sw_cmd_arg_i,
    input  logic [1:0]  sw_rsp_type_i,
    input  logic        sw_data_present_i,
    input  logic        auto_cmd12_req_i,
    input  logic        dat_active_i,
    input  logic        cmd_ready_i,
    input  logic        cmd_done_i,
    input  logic        rsp_done_i,
    output logic        cmd_start_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [1:0]  cmd_rsp_type_o,
    output logic        inhibit_cmd_o,
    output logic        inhibit_dat_o,
    output logic        sw_cmd_drop_o,
    output logic        cmd_complete_o,
    output logic        auto_cmd12_done_o,
    output logic        rsp_timeout_o
);

    localparam int unsigned IdxW = 6;
    localparam int unsigned ArgW = 32;
    localparam int unsigned TypW = 2;
    localparam int unsigned CntW = 7;

    localparam logic [IdxW-1:0] StopIdx  = IdxW'(12);
    localparam logic [TypW-1:0] StopType = TypW'(3);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(RspTimeout);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CMD,
        ST_WAIT_RSP,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              sw_pend_q, sw_pend_d;
    logic              auto_pend_q, auto_pend_d;
    logic              sel_auto_q, sel_auto_d;
    logic [IdxW-1:0]   slot_idx_q, slot_idx_d;
    logic [ArgW-1:0]   slot_arg_q, slot_arg_d;
    logic [TypW-1:0]   slot_type_q, slot_type_d;
    logic              slot_data_q, slot_data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              start_q, start_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ArgW-1:0]   arg_q, arg_d;
    logic [TypW-1:0]   type_q, type_d;
    logic              drop_q, drop_d;
    logic              complete_q, complete_d;
    logic              auto_done_q, auto_done_d;
    logic              timeout_q, timeout_d;
    logic              sw_accept;
    logic [CntW-1:0]   cnt_inc;

    // Software slot stays "in flight" until DONE clears its pending bit.
    assign inhibit_cmd_o = (state_q != ST_IDLE) | sw_pend_q;
    assign inhibit_dat_o = dat_active_i | (sw_pend_q & slot_data_q);

    assign sw_accept = sw_cmd_valid_i & ~inhibit_cmd_o & ~(sw_data_present_i & inhibit_dat_o);
    assign cnt_inc   = cnt_q + CntW'(1);

    always_comb begin
        state_d     = state_q;
        sw_pend_d   = sw_pend_q;
        auto_pend_d = auto_pend_q;
        sel_auto_d  = sel_auto_q;
        slot_idx_d  = slot_idx_q;
        slot_arg_d  = slot_arg_q;
        slot_type_d = slot_type_q;
        slot_data_d = slot_data_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        type_d      = type_q;
        drop_d      = sw_cmd_valid_i & ~sw_accept;
        complete_d  = 1'b0;
        auto_done_d = 1'b0;
        timeout_d   = 1'b0;

        if (sw_accept) begin
            sw_pend_d   = 1'b1;
            slot_idx_d  = sw_cmd_index_i;
            slot_arg_d  = sw_cmd_arg_i;
            slot_type_d = sw_rsp_type_i;
            slot_data_d = sw_data_present_i;
        end
        if (auto_cmd12_req_i) begin
            auto_pend_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (auto_pend_q) begin
                    sel_auto_d = 1'b1;
                    idx_d      = StopIdx;
                    arg_d      = '0;
                    type_d     = StopType;
                    start_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end else if (sw_pend_q) begin
                    sel_auto_d = 1'b0;
                    idx_d      = slot_idx_q;
                    arg_d      = slot_arg_q;
                    type_d     = slot_type_q;
                    start_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (start_q && cmd_ready_i) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT_CMD;
                end
            end
            ST_WAIT_CMD: begin
                if (cmd_done_i) begin
                    if (type_q != TypW'(0)) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_RSP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_done_i) begin
                    state_d = ST_DONE;
                end else if (sd_clk_en_p_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutCnt) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A CMD12 request arriving now merges into the one completing.
                if (sel_auto_q) begin
                    auto_pend_d = 1'b0;
                    auto_done_d = 1'b1;
                end else begin
                    sw_pend_d  = 1'b0;
                    complete_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sw_pend_q   <= 1'b0;
            auto_pend_q <= 1'b0;
            sel_auto_q  <= 1'b0;
            slot_idx_q  <= '0;
            slot_arg_q  <= '0;
            slot_type_q <= '0;
            slot_data_q <= 1'b0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            idx_q       <= '0;
            arg_q       <= '0;
            type_q      <= '0;
            drop_q      <= 1'b0;
            complete_q  <= 1'b0;
            auto_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_pend_q   <= sw_pend_d;
            auto_pend_q <= auto_pend_d;
            sel_auto_q  <= sel_auto_d;
            slot_idx_q  <= slot_idx_d;
            slot_arg_q  <= slot_arg_d;
            slot_type_q <= slot_type_d;
            slot_data_q <= slot_data_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            type_q      <= type_d;
            drop_q      <= drop_d;
            complete_q  <= complete_d;
            auto_done_q <= auto_done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_start_o       = start_q;
    assign cmd_index_o       = idx_q;
    assign cmd_arg_o         = arg_q;
    assign cmd_rsp_type_o    = type_q;
    assign sw_cmd_drop_o     = drop_q;
    assign cmd_complete_o    = complete_q;
    assign auto_cmd12_done_o = auto_done_q;
    assign rsp_timeout_o     = timeout_q;

endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 SHALL have parameter RspTimeout, default 64, response wait limit in SD clock enables (range 2..127).
REQ-002 SHALL have port clk_i  in  1  system clock; every flop on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port sd_clk_en_p_i  in  1  SD clock rising-edge enable; timeout time base.
REQ-005 SHALL have port sw_cmd_valid_i  in  1  one-cycle strobe, software command register write.
REQ-006 SHALL have port sw_cmd_index_i  in  6  software command index.
REQ-007 SHALL have port sw_cmd_arg_i  in  32  software command argument.
REQ-008 SHALL have port sw_rsp_type_i  in  2  response type: 0 none, 1 R136, 2 R48, 3 R48 busy.
REQ-009 SHALL have port sw_data_present_i  in  1  software command uses DAT line.
REQ-010 SHALL have port auto_cmd12_req_i  in  1  one-cycle CMD12 request from data wrapper.
REQ-011 SHALL have port dat_active_i  in  1  read or write transfer active on DAT.
REQ-012 SHALL have port cmd_ready_i  in  1  command path accepts start.
REQ-013 SHALL have port cmd_done_i  in  1  one-cycle pulse, command bits sent.
REQ-014 SHALL have port rsp_done_i  in  1  one-cycle pulse, response received.
REQ-015 SHALL have port cmd_start_o  out  1  start valid toward command path.
REQ-016 SHALL have port cmd_index_o  out  6  index of selected command.
REQ-017 SHALL have port cmd_arg_o  out  32  argument of selected command.
REQ-018 SHALL have port cmd_rsp_type_o  out  2  response type of selected command.
REQ-019 SHALL have port inhibit_cmd_o  out  1  Command Inhibit (CMD) status.
REQ-020 SHALL have port inhibit_dat_o  out  1  Command Inhibit (DAT) status.
REQ-021 SHALL have port sw_cmd_drop_o  out  1  one-cycle pulse, software command rejected.
REQ-022 SHALL have port cmd_complete_o  out  1  one-cycle pulse, software command complete.
REQ-023 SHALL have port auto_cmd12_done_o  out  1  one-cycle pulse, auto CMD12 complete.
REQ-024 SHALL have port rsp_timeout_o  out  1  one-cycle pulse, response timeout.

Function
REQ-025 SHALL hold one software slot (index, arg, type, data flag, pending bit) and one auto pending bit.
REQ-026 SHALL capture sw_cmd_valid_i only if inhibit_cmd_o=0 and not (sw_data_present_i and inhibit_dat_o); otherwise pulse sw_cmd_drop_o next cycle, slot unchanged.
REQ-027 SHALL set auto pending on auto_cmd12_req_i; a request while already pending merges (no second CMD12).
REQ-028 SHALL run FSM IDLE -> ISSUE -> WAIT_CMD -> (WAIT_RSP) -> DONE -> IDLE.
REQ-029 IDLE: auto pending wins over software pending; selected source latched; ISSUE next cycle; nothing pending stays IDLE.
REQ-030 ISSUE: cmd_start_o=1 with stable index/arg/type; leave to WAIT_CMD on the cycle cmd_start_o and cmd_ready_i are both 1.
REQ-031 Auto CMD12 SHALL drive index 12, arg 0, rsp type 3.
REQ-032 WAIT_CMD: on cmd_done_i go WAIT_RSP if rsp type != 0, else DONE.
REQ-033 WAIT_RSP: 7-bit counter cleared on entry, +1 per sd_clk_en_p_i; rsp_done_i -> DONE; count reaching RspTimeout -> pulse rsp_timeout_o, DONE; rsp_done_i wins on same cycle.
REQ-034 DONE: one cycle; clear selected pending bit; pulse cmd_complete_o (software) or auto_cmd12_done_o (auto), also after timeout.
REQ-035 inhibit_cmd_o = (state != IDLE) or software pending, registered-state derived, combinational.
REQ-036 inhibit_dat_o = dat_active_i or (software slot pending/in flight with data flag).
REQ-037 Strobes during ISSUE..DONE SHALL follow REQ-026/027; sw and auto strobes in same cycle both captured, auto issued first.

Reset
REQ-038 On rst_ni=0 at a clock edge: state IDLE, pending bits, slot, counter cleared; all outputs 0 (inhibit_dat_o follows dat_active_i) from next cycle, mid-operation included.

Verification
REQ-039 sw CMD17 arg 0x200 type 2, cmd_ready_i=1 -> cmd_start_o one cycle, index 17, arg 0x200; after cmd_done_i, rsp_done_i -> cmd_complete_o one pulse.
REQ-040 sw_cmd_valid_i while in WAIT_RSP -> sw_cmd_drop_o pulse, no second start.
REQ-041 auto_cmd12_req_i and sw_cmd_valid_i same cycle -> CMD12 arg 0 issued first, then sw command; auto_cmd12_done_o then cmd_complete_o.
REQ-042 RspTimeout=64, no rsp_done_i -> rsp_timeout_o after 64th sd_clk_en_p_i, then cmd_complete_o, IDLE.
REQ-043 data command while dat_active_i=1 -> dropped; non-data command accepted.
REQ-044 rst_ni=0 during WAIT_CMD -> IDLE, all outputs 0 next cycle, pending cleared.
